// File: rtl/io_pkg.sv
// Shared constants and bus payload types for the I/O responder.
// Build option: IO_OVERRUN_EN adds per-port sticky overrun flags on the IN path.
package io_pkg;

    localparam int unsigned IO_WIDTH  = 8;
    localparam int unsigned IO_NPORTS = 4;
    localparam int unsigned IO_PW     = 2;
    localparam int unsigned IO_DEPTH  = 4;

    // One buffered OUT write: destination port tag plus data byte.
    typedef struct packed {
        logic [IO_PW-1:0]    port;
        logic [IO_WIDTH-1:0] data;
    } io_entry_t;

endpackage

// File: rtl/io_responder_if.sv
// CPU-side and device-side signals of the I/O responder.
//   cpu_*  : CPU IN/OUT strobes, port select, write data, read data, stall
//   out_*  : OUT valid/ready handshake toward the external device
//   in_*   : per-port capture strobes/bytes from devices, avail flags
//   in_overrun : sticky per-port overwrite flags (only with IO_OVERRUN_EN)
// master = CPU/devices side, slave = responder side.
interface io_responder_if;
    import io_pkg::*;

    logic                          cpu_we;
    logic                          cpu_re;
    logic [IO_PW-1:0]              cpu_addr;
    logic [IO_WIDTH-1:0]           cpu_wdata;
    logic [IO_WIDTH-1:0]           cpu_rdata;
    logic                          cpu_stall;
    logic [IO_NPORTS-1:0]          in_avail;
    logic                          out_valid;
    logic                          out_ready;
    logic [IO_PW-1:0]              out_port;
    logic [IO_WIDTH-1:0]           out_data;
    logic [IO_NPORTS-1:0]          in_valid;
    logic [IO_NPORTS*IO_WIDTH-1:0] in_data;
`ifdef IO_OVERRUN_EN
    logic [IO_NPORTS-1:0]          in_overrun;
`endif

    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wdata, out_ready, in_valid, in_data,
`ifdef IO_OVERRUN_EN
        input  in_overrun,
`endif
        input  cpu_rdata, cpu_stall, in_avail, out_valid, out_port, out_data
    );

    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wdata, out_ready, in_valid, in_data,
`ifdef IO_OVERRUN_EN
        output in_overrun,
`endif
        output cpu_rdata, cpu_stall, in_avail, out_valid, out_port, out_data
    );

endinterface

// File: rtl/io_fifo.sv
// Synchronous FIFO with async active-high reset.
// Ports: push/din write the tail (ignored when full), pop removes the head
// (ignored when empty), dout shows the head combinationally (0 when empty),
// full/empty/count report occupancy. DEPTH must be a power of 2, >= 2.
module io_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned EW    = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [EW-1:0]                din,
    output logic [EW-1:0]                dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/io_responder.sv
// Peripheral-side responder for the CPU's IN/OUT instructions.
// Ports: clk, reset (async, active-high), bus (io_responder_if.slave).
// OUT writes are buffered in io_fifo and drained over out_valid/out_ready;
// cpu_stall is raised while a write targets a full FIFO. IN bytes are
// captured per port into holding registers with in_avail flags; cpu_rdata
// reads the selected holding register combinationally.
// Build option: IO_OVERRUN_EN adds sticky in_overrun flags.
module io_responder
    import io_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    io_responder_if.slave  bus
);

    localparam int unsigned CW = $clog2(IO_DEPTH + 1);

    io_entry_t             fifo_din;
    io_entry_t             fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count_unused;

    logic [IO_WIDTH-1:0]   hold_q [IO_NPORTS];
    logic [IO_WIDTH-1:0]   hold_d [IO_NPORTS];
    logic [IO_NPORTS-1:0]  avail_q, avail_d;

    assign fifo_din = '{port: bus.cpu_addr, data: bus.cpu_wdata};

    io_fifo #(
        .DEPTH (IO_DEPTH),
        .EW    ($bits(io_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.cpu_we),
        .pop   (bus.out_ready),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    // A full FIFO blocks the write even if the head leaves this cycle.
    assign bus.cpu_stall = bus.cpu_we & fifo_full;
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_port  = fifo_dout.port;
    assign bus.out_data  = fifo_dout.data;

    assign bus.cpu_rdata = hold_q[bus.cpu_addr];
    assign bus.in_avail  = avail_q;

    // Read clears first so that a same-port capture overrides it.
    always_comb begin
        hold_d  = hold_q;
        avail_d = avail_q;
        if (bus.cpu_re) begin
            avail_d[bus.cpu_addr] = 1'b0;
        end
        for (int p = 0; p < IO_NPORTS; p++) begin
            if (bus.in_valid[p]) begin
                hold_d[p]  = bus.in_data[p*IO_WIDTH +: IO_WIDTH];
                avail_d[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q  <= '{default: '0};
            avail_q <= '0;
        end else begin
            hold_q  <= hold_d;
            avail_q <= avail_d;
        end
    end

`ifdef IO_OVERRUN_EN
    logic [IO_NPORTS-1:0] ovr_q, ovr_d;

    // Overrun = capture onto unread data that no same-cycle read consumes.
    always_comb begin
        ovr_d = ovr_q;
        for (int p = 0; p < IO_NPORTS; p++) begin
            if (bus.cpu_re && (bus.cpu_addr == IO_PW'(p))) begin
                ovr_d[p] = 1'b0;
            end else if (bus.in_valid[p] && avail_q[p]) begin
                ovr_d[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign bus.in_overrun = ovr_q;
`endif

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: queue/array reference model compared
// on every falling edge, plus directed literal expectations.
module tb_io_responder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    io_responder_if bus ();

    io_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    bit          run_cmp = 1'b0;

    // Reference model: OUT FIFO as a queue of {port,data}, IN side as arrays.
    logic [9:0] mq[$];
    logic [7:0] mhold [4];
    logic [3:0] mavail = '0;
    logic [3:0] movr = '0;
    logic [3:0] nxt_ovr;
    logic       m_pop, m_push;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            for (int p = 0; p < 4; p++) mhold[p] = 8'h00;
            mavail = '0;
            movr   = '0;
        end else begin
            m_pop  = bus.out_ready && (mq.size() != 0);
            m_push = bus.cpu_we && (mq.size() < 4);
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back({bus.cpu_addr, bus.cpu_wdata});
            nxt_ovr = movr;
            for (int p = 0; p < 4; p++) begin
                if (bus.cpu_re && bus.cpu_addr == 2'(p)) nxt_ovr[p] = 1'b0;
                if (bus.in_valid[p] && mavail[p] && !(bus.cpu_re && bus.cpu_addr == 2'(p)))
                    nxt_ovr[p] = 1'b1;
            end
            movr = nxt_ovr;
            if (bus.cpu_re) mavail[bus.cpu_addr] = 1'b0;
            for (int p = 0; p < 4; p++) begin
                if (bus.in_valid[p]) begin
                    mhold[p]  = bus.in_data[p*8 +: 8];
                    mavail[p] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("stall", 32'(bus.cpu_stall), 32'(bus.cpu_we && mq.size() == 4));
            chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
            chk("out_port", 32'(bus.out_port), (mq.size() != 0) ? 32'(mq[0][9:8]) : 32'd0);
            chk("out_data", 32'(bus.out_data), (mq.size() != 0) ? 32'(mq[0][7:0]) : 32'd0);
            chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(mhold[bus.cpu_addr]));
            chk("in_avail", 32'(bus.in_avail), 32'(mavail));
`ifdef IO_OVERRUN_EN
            chk("in_overrun", 32'(bus.in_overrun), 32'(movr));
`endif
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [1:0] a, input logic [7:0] d);
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        tick();
        bus.cpu_we    = 1'b0;
    endtask

    task automatic in_pulse(input int p, input logic [7:0] d);
        bus.in_valid        = '0;
        bus.in_valid[p]     = 1'b1;
        bus.in_data         = '0;
        bus.in_data[p*8 +: 8] = d;
        tick();
        bus.in_valid        = '0;
    endtask

    initial begin
        bus.cpu_we = 0; bus.cpu_re = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.out_ready = 0; bus.in_valid = 0; bus.in_data = 0;
        for (int p = 0; p < 4; p++) mhold[p] = 8'h00;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_avail", 32'(bus.in_avail), 32'd0);
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_rdata", 32'(bus.cpu_rdata), 32'd0);
        tick(2);
        reset = 1'b0;
        run_cmp = 1'b1;

        // OUT ordering and one-cycle push latency
        bus.cpu_we = 1; bus.cpu_addr = 2'd1; bus.cpu_wdata = 8'h11;
        #1 chk("lat_before_edge", 32'(bus.out_valid), 32'd0);
        tick();
        bus.cpu_we = 0;
        chk("lat_after_edge", 32'(bus.out_valid), 32'd1);
        push(2'd2, 8'h22);
        push(2'd3, 8'h33);
        chk("ord0_port", 32'(bus.out_port), 32'd1);
        chk("ord0_data", 32'(bus.out_data), 32'h11);
        tick(2);
        chk("hold_stable", 32'(bus.out_data), 32'h11);
        bus.out_ready = 1;
        tick();
        chk("ord1", 32'({bus.out_port, bus.out_data}), 32'h222);
        tick();
        chk("ord2", 32'({bus.out_port, bus.out_data}), 32'h333);
        tick();
        chk("ord_empty_valid", 32'(bus.out_valid), 32'd0);
        chk("ord_empty_data", 32'(bus.out_data), 32'd0);
        bus.out_ready = 0;

        // Full / stall
        push(2'd0, 8'h41); push(2'd0, 8'h42); push(2'd0, 8'h43); push(2'd0, 8'h44);
        bus.cpu_we = 1; bus.cpu_addr = 2'd3; bus.cpu_wdata = 8'h55;
        #1 chk("full_stall", 32'(bus.cpu_stall), 32'd1);
        tick();
        chk("full_stall_hold", 32'(bus.cpu_stall), 32'd1);
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        #1 chk("stall_drop", 32'(bus.cpu_stall), 32'd0);
        chk("head_after_pop", 32'(bus.out_data), 32'h42);
        tick();
        bus.cpu_we = 0;
        bus.out_ready = 1;
        tick(3);
        chk("tail_55", 32'({bus.out_port, bus.out_data}), 32'h355);
        tick();
        chk("drained", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 0;

        // IN capture / read
        in_pulse(2, 8'hA5);
        chk("cap_avail", 32'(bus.in_avail), 32'b0100);
        bus.cpu_addr = 2'd2;
        #1 chk("cap_rdata", 32'(bus.cpu_rdata), 32'hA5);
        bus.cpu_re = 1;
        tick();
        bus.cpu_re = 0;
        chk("read_clears", 32'(bus.in_avail), 32'd0);
        chk("stale_rdata", 32'(bus.cpu_rdata), 32'hA5);

        // IN collision: capture wins over read on the same port
        in_pulse(1, 8'h10);
        bus.cpu_addr = 2'd1; bus.cpu_re = 1;
        bus.in_valid = 4'b0010; bus.in_data = '0; bus.in_data[15:8] = 8'h20;
        #1 chk("coll_old_byte", 32'(bus.cpu_rdata), 32'h10);
        tick();
        bus.cpu_re = 0; bus.in_valid = '0;
        chk("coll_new_byte", 32'(bus.cpu_rdata), 32'h20);
        chk("coll_avail", 32'(bus.in_avail[1]), 32'd1);
        bus.cpu_re = 1;
        tick();
        bus.cpu_re = 0;

`ifdef IO_OVERRUN_EN
        // Overrun: second capture with no read in between
        in_pulse(0, 8'h01);
        in_pulse(0, 8'h02);
        bus.cpu_addr = 2'd0;
        #1 chk("ovr_set", 32'(bus.in_overrun[0]), 32'd1);
        chk("ovr_data", 32'(bus.cpu_rdata), 32'h02);
        bus.cpu_re = 1;
        tick();
        bus.cpu_re = 0;
        chk("ovr_clear", 32'(bus.in_overrun[0]), 32'd0);
        chk("ovr_avail", 32'(bus.in_avail[0]), 32'd0);
`endif

        // Simultaneous push+pop mid-occupancy, with a concurrent IN read
        push(2'd0, 8'h61); push(2'd1, 8'h62);
        in_pulse(2, 8'h77);
        bus.cpu_we = 1; bus.out_ready = 1; bus.cpu_re = 1;
        bus.cpu_addr = 2'd2; bus.cpu_wdata = 8'h63;
        tick();
        bus.cpu_re = 0; bus.cpu_wdata = 8'h64;
        tick();
        bus.cpu_we = 0; bus.out_ready = 0;
        chk("pp_head", 32'({bus.out_port, bus.out_data}), 32'h263);
        chk("pp_re_clear", 32'(bus.in_avail), 32'd0);

        // Reset mid-operation
        push(2'd0, 8'h71); push(2'd1, 8'h72); push(2'd2, 8'h73);
        in_pulse(3, 8'h99);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_avail", 32'(bus.in_avail), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_data", 32'(bus.out_data), 32'd0);
        chk("post_rst_port", 32'(bus.out_port), 32'd0);

        tick(2);
        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Peripheral-side responder for the monocycle CPU's IN/OUT instructions; it is the far end of the CPU's I/O port interface.
- OUT path: buffers CPU writes (port tag + byte) in a small FIFO and drains them to the external device over a valid/ready handshake.
- IN path: captures bytes offered by external devices into per-port holding registers with "data available" flags. The CPU reads them combinationally within its single cycle.

Parameters:
- WIDTH, 8, data width of each port byte
- NPORTS, 4, number of I/O ports; PW = clog2(NPORTS) = 2
- DEPTH, 4, OUT FIFO entries (power of 2, >= 2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- cpu_we  in  1  CPU OUT strobe: write cpu_wdata to port cpu_addr
- cpu_re  in  1  CPU IN strobe: consume byte of port cpu_addr
- cpu_addr  in  PW  port selector for OUT and IN
- cpu_wdata  in  WIDTH  OUT data
- cpu_rdata  out  WIDTH  IN data, combinational from holding register
- cpu_stall  out  1  combinational; CPU must freeze its PC this cycle
- in_avail  out  NPORTS  per-port data-available flags, CPU-visible for branching
- out_valid  out  1  external OUT handshake: FIFO head valid
- out_ready  in  1  external OUT handshake: device accepts head
- out_port  out  PW  port tag of FIFO head
- out_data  out  WIDTH  data of FIFO head
- in_valid  in  NPORTS  per-port strobe from external device, 1-cycle pulse
- in_data  in  NPORTS*WIDTH  per-port bytes; port p occupies bits [p*WIDTH +: WIDTH]

Behaviour:
- Reset, async, immediate: FIFO empty (count=0, rd/wr pointers 0), out_valid=0, out_port=0, out_data=0, all holding registers 0, in_avail=0, cpu_stall=0. Any in-flight handshake is dropped.
- OUT push:
  - When cpu_we=1 and count<DEPTH, the entry {cpu_addr, cpu_wdata} is written at wr_ptr on the clock edge.
  - wr_ptr wraps modulo DEPTH.
- OUT full:
  - cpu_stall = cpu_we & (count==DEPTH), with no push.
  - A pop in the same cycle does not allow a push; the CPU retries next cycle, when stall drops.
  - The stall adds exactly one extra cycle if the device pops.
- OUT pop:
  - out_valid = (count!=0); out_port and out_data come from the head entry, combinationally from storage.
  - On out_valid & out_ready the head is removed and rd_ptr wraps modulo DEPTH.
  - out_data and out_port must stay stable while out_valid=1 and out_ready=0.
  - When empty they read as 0.
- Simultaneous push and pop with 0<count<DEPTH: count is unchanged, both pointers advance.
- Push to an empty FIFO: out_valid rises the cycle after the push edge, i.e. one cycle of latency.
- IN capture:
  - in_valid[p]=1 loads holding[p] from in_data slice p and sets in_avail[p].
  - Ports are independent; several may capture in the same cycle.
- IN read:
  - cpu_rdata = holding[cpu_addr] regardless of cpu_re.
  - On an edge with cpu_re=1, in_avail[cpu_addr] clears.
- IN simultaneous capture and read on the same port: the capture wins. The new byte is loaded, in_avail stays 1, and the CPU saw the old byte this cycle.
- Reading a port with in_avail=0 returns the stale byte (0 after reset) with no error.
- cpu_we and cpu_re in the same cycle are legal and independent.

Optional Feature:
- Macro: IO_OVERRUN_EN.
- With the macro defined:
  - Extra output in_overrun [NPORTS], reset 0.
  - in_overrun[p] sets, sticky, when in_valid[p]=1 while in_avail[p]=1 and no same-cycle cpu_re consumes port p.
  - in_overrun[p] clears on the edge where cpu_re=1 with cpu_addr=p and there is no new overrun.
  - The data is still overwritten.
- Without the macro: the port is absent and overwrite is silent.

Decomposition:
- Shared package io_pkg:
  - constants IO_WIDTH=8, IO_NPORTS=4, IO_PW=2, IO_DEPTH=4
  - typedef io_entry_t {port[PW], data[WIDTH]}
- One sub-module: io_fifo, a synchronous FIFO with async reset.
  - Ports: push, pop, din, dout, full, empty, count.
  - Parameterized on DEPTH and entry width.
  - The IN holding logic stays in the top level.

Test Plan:
- Reset mid-operation: push 3 entries, assert reset for 1 cycle -> out_valid=0, count=0, in_avail=0 immediately; after release out_data=0.
- OUT ordering: out_ready=0, then writes (port1,0x11), (port2,0x22), (port3,0x33). Raise out_ready -> pops in order 1/0x11, 2/0x22, 3/0x33 on consecutive cycles, then out_valid=0.
- Full/stall: out_ready=0, 4 pushes, 5th cpu_we with 0x55 -> cpu_stall=1 and no push. Pulse out_ready one cycle -> next cycle cpu_stall=0 and 0x55 accepted at the tail.
- IN capture/read: in_valid[2] with byte 0xA5 -> in_avail=4'b0100. cpu_addr=2 gives cpu_rdata=0xA5; cpu_re clears in_avail[2] next edge.
- IN collision: in_avail[1]=1 holding 0x10; same cycle cpu_re on port 1 and in_valid[1] with 0x20 -> cpu_rdata=0x10 that cycle, then holding=0x20 and in_avail[1]=1.
- IO_OVERRUN_EN: two in_valid[0] pulses (0x01, 0x02) with no read -> in_overrun[0]=1, holding=0x02. cpu_re on port 0 -> in_overrun[0]=0 and in_avail[0]=0.
